// File: rtl/fm_radio_pkg.sv
// fm_radio_pkg
// Shared constants and helpers for the FM receiver audio chain.
//   FM_DATA_WIDTH / FM_NUM_TAPS : default sample width and low-pass length
//   QUANT_BITS_DEFAULT          : fixed-point fraction bits (1.0 = 2**10)
//   AUDIO_LPR_COEFFS            : symmetric audio low-pass taps, all in (0,1024)
//   fir_decim_state_t           : decimating FIR controller states
//   dq()                        : dequantize, signed divide by 2**frac_bits toward zero
package fm_radio_pkg;

   localparam int FM_DATA_WIDTH      = 32;
   localparam int FM_NUM_TAPS        = 32;
   localparam int QUANT_BITS_DEFAULT = 10;
   localparam int DQ_WIDTH           = 2 * FM_DATA_WIDTH;

   localparam logic signed [FM_DATA_WIDTH-1:0] AUDIO_LPR_COEFFS [FM_NUM_TAPS] = '{
      32'sd3,   32'sd5,   32'sd8,   32'sd12,  32'sd18,  32'sd25,  32'sd34,  32'sd44,
      32'sd55,  32'sd67,  32'sd79,  32'sd91,  32'sd102, 32'sd112, 32'sd120, 32'sd125,
      32'sd125, 32'sd120, 32'sd112, 32'sd102, 32'sd91,  32'sd79,  32'sd67,  32'sd55,
      32'sd44,  32'sd34,  32'sd25,  32'sd18,  32'sd12,  32'sd8,   32'sd5,   32'sd3
   };

   typedef enum logic [1:0] {
      S_LOAD,
      S_MAC,
      S_OUT
   } fir_decim_state_t;

   // Negative values get a bias of 2**frac_bits-1 before the arithmetic shift so the
   // result rounds toward zero like a signed division (dq(-1) = 0, dq(-1025) = -1).
   function automatic logic signed [DQ_WIDTH-1:0] dq(
      input logic signed [DQ_WIDTH-1:0] value,
      input int unsigned                frac_bits
   );
      logic signed [DQ_WIDTH-1:0] bias;
      bias = '0;
      if (value[DQ_WIDTH-1]) begin
         bias = (DQ_WIDTH'(1) << frac_bits) - DQ_WIDTH'(1);
      end
      return (value + bias) >>> frac_bits;
   endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac
// Registered multiply-dequantize-accumulate unit: one coefficient x sample per clock.
//   clock, reset     : clock, asynchronous active-high reset
//   clear            : zero the accumulator (start of a new output)
//   enable           : add dq(coeff*sample) into the accumulator
//   coeff, sample    : signed operands
//   acc_next         : accumulator value including the current term (combinational),
//                      so the caller can capture the final sum on the last tap edge
module fir_mac
   import fm_radio_pkg::*;
#(
   parameter int DATA_WIDTH = FM_DATA_WIDTH,
   parameter int ACC_WIDTH  = FM_DATA_WIDTH,
   parameter int QUANT_BITS = QUANT_BITS_DEFAULT
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         enable,
   input  logic signed [DATA_WIDTH-1:0] coeff,
   input  logic signed [DATA_WIDTH-1:0] sample,
   output logic signed [ACC_WIDTH-1:0]  acc_next
);

   logic signed [2*DATA_WIDTH-1:0] product;
   logic signed [DQ_WIDTH-1:0]     term;
   logic signed [ACC_WIDTH-1:0]    acc;

   // Full-width signed product, dequantized, then folded into the accumulator width;
   // dropping the upper term bits gives the modulo wrap of the accumulator.
   always_comb begin
      product  = (2*DATA_WIDTH)'(coeff) * (2*DATA_WIDTH)'(sample);
      term     = dq(DQ_WIDTH'(product), QUANT_BITS);
      acc_next = acc + term[ACC_WIDTH-1:0];
   end

   // Clear wins over enable so a new output always starts from zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/fir_decim.sv
// fir_decim
// Audio-band low-pass decimating FIR: one output per DECIM accepted samples, computed
// with a single time-multiplexed multiplier (one tap per clock).
//   clock, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready/din : input sample handshake (accept = in_valid & in_ready)
//   out_valid/out_ready/dout : filtered result handshake, dout/out_valid registered
// Build option: define FIR_DECIM_SAT_EN to widen the accumulator with guard bits and
// clamp the result to the DATA_WIDTH range; otherwise the sum wraps modulo 2**DATA_WIDTH.
module fir_decim
   import fm_radio_pkg::*;
#(
   parameter int DATA_WIDTH = FM_DATA_WIDTH,
   parameter int NUM_TAPS   = FM_NUM_TAPS,
   parameter int DECIM      = 8,
   parameter int QUANT_BITS = QUANT_BITS_DEFAULT
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] din,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] dout
);

   localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef FIR_DECIM_SAT_EN
   localparam int ACC_WIDTH = DATA_WIDTH + $clog2(NUM_TAPS);
`else
   localparam int ACC_WIDTH = DATA_WIDTH;
`endif
   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

   fir_decim_state_t             state;
   fir_decim_state_t             state_next;
   logic signed [DATA_WIDTH-1:0] history [NUM_TAPS];
   logic [CNT_W-1:0]             load_cnt;
   logic [TAP_W-1:0]             tap_idx;
   logic                         in_ready_q;
   logic                         accept;
   logic                         last_accept;
   logic                         mac_last;
   logic                         out_fire;
   logic signed [DATA_WIDTH-1:0] tap_coeff;
   logic signed [DATA_WIDTH-1:0] tap_sample;
   logic signed [ACC_WIDTH-1:0]  acc_next;
   logic signed [DATA_WIDTH-1:0] result;

   assign in_ready    = in_ready_q;
   assign accept      = in_valid && in_ready_q;
   assign last_accept = accept && (load_cnt == CNT_LAST);
   assign mac_last    = (state == S_MAC) && (tap_idx == TAP_LAST);
   assign out_fire    = (state == S_OUT) && out_ready;

   // Tap k pairs the newest-first history x[k] with coefficient NUM_TAPS-1-k.
   assign tap_coeff  = DATA_WIDTH'(AUDIO_LPR_COEFFS[TAP_LAST - tap_idx]);
   assign tap_sample = history[tap_idx];

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_LOAD;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state: load DECIM samples, walk every tap, then hold until taken.
   always_comb begin
      state_next = state;
      case (state)
         S_LOAD:  if (last_accept) state_next = S_MAC;
         S_MAC:   if (tap_idx == TAP_LAST) state_next = S_OUT;
         S_OUT:   if (out_ready) state_next = S_LOAD;
         default: state_next = S_LOAD;
      endcase
   end

   // in_ready is a registered copy of "next state is S_LOAD"; it stays low through reset
   // and rises on the first edge afterwards, with no path from any input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= (state_next == S_LOAD);
      end
   end

   // Sample history shift register, x[0] newest.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < NUM_TAPS; j++) begin
            history[j] <= '0;
         end
      end else if (accept) begin
         history[0] <= din;
         for (int j = 1; j < NUM_TAPS; j++) begin
            history[j] <= history[j-1];
         end
      end
   end

   // Load counter and tap index; both return to zero when their phase ends.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         load_cnt <= '0;
         tap_idx  <= '0;
      end else begin
         if (accept) begin
            load_cnt <= last_accept ? '0 : load_cnt + 1'b1;
         end
         if (state == S_MAC) begin
            tap_idx <= mac_last ? '0 : tap_idx + 1'b1;
         end else begin
            tap_idx <= '0;
         end
      end
   end

   fir_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .QUANT_BITS (QUANT_BITS)
   ) u_mac (
      .clock    (clock),
      .reset    (reset),
      .clear    (last_accept),
      .enable   (state == S_MAC),
      .coeff    (tap_coeff),
      .sample   (tap_sample),
      .acc_next (acc_next)
   );

   // Final sum narrowed to the output width, clamped when guard bits are present.
   always_comb begin
      result = acc_next[DATA_WIDTH-1:0];
`ifdef FIR_DECIM_SAT_EN
      if (acc_next > ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}})) begin
         result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (acc_next < $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}})) begin
         result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end
`endif
   end

   // Output register: captured on the last tap edge, held until the downstream takes it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         dout      <= '0;
      end else if (mac_last) begin
         out_valid <= 1'b1;
         dout      <= result;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_decim.sv
// tb_fir_decim
// Self-checking bench for fir_decim. A negedge monitor keeps a newest-first sample
// history and computes each expected output straight from the filter equation
// (sum of coeff*x / 2**QUANT_BITS with truncating division, then wrap/clamp).
module tb_fir_decim;
   import fm_radio_pkg::*;

   localparam int DATA_WIDTH = FM_DATA_WIDTH;
   localparam int NUM_TAPS   = FM_NUM_TAPS;
   localparam int DECIM      = 8;
   localparam int QUANT_BITS = QUANT_BITS_DEFAULT;

   logic                         clock = 1'b0;
   logic                         reset = 1'b1;
   logic                         in_valid = 1'b0;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] din = '0;
   logic                         out_valid;
   logic                         out_ready = 1'b0;
   logic signed [DATA_WIDTH-1:0] dout;

   int     compare_count  = 0;
   int     mismatch_count = 0;
   longint hist [NUM_TAPS];
   longint exp_q [$];
   int     load_count   = 0;
   int     accept_count = 0;
   int     out_count    = 0;
   longint last_out     = 0;

   fir_decim #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_TAPS   (NUM_TAPS),
      .DECIM      (DECIM),
      .QUANT_BITS (QUANT_BITS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout)
   );

   always #5 clock = ~clock;

   task automatic check_output(input string tag, input longint observed, input longint expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference output from the current history, straight from the filter equation.
   function automatic longint model_y();
      longint                       s;
      logic signed [DATA_WIDTH-1:0] w;
      s = 0;
      for (int j = 0; j < NUM_TAPS; j++) begin
         s += (longint'(AUDIO_LPR_COEFFS[NUM_TAPS-1-j]) * hist[j]) / (longint'(1) << QUANT_BITS);
      end
`ifdef FIR_DECIM_SAT_EN
      if (s > (longint'(1) << (DATA_WIDTH-1)) - 1) s = (longint'(1) << (DATA_WIDTH-1)) - 1;
      if (s < -(longint'(1) << (DATA_WIDTH-1)))    s = -(longint'(1) << (DATA_WIDTH-1));
`endif
      w = s[DATA_WIDTH-1:0];
      return longint'(w);
   endfunction

   // Monitor: handshakes seen at the negedge complete on the following posedge.
   always @(negedge clock) begin
      if (reset) begin
         foreach (hist[j]) hist[j] = 0;
         load_count = 0;
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            check_output("accept_while_busy", longint'(exp_q.size()), 0);
            for (int j = NUM_TAPS-1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = longint'(din);
            accept_count++;
            load_count++;
            if (load_count == DECIM) begin
               exp_q.push_back(model_y());
               load_count = 0;
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_output("spurious_output", longint'(exp_q.size()), 1);
            end else begin
               check_output("dout", longint'(dout), exp_q.pop_front());
            end
            last_out = longint'(dout);
            out_count++;
         end
      end
   end

   task automatic apply_reset();
      @(posedge clock); #1;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_output("rst_in_ready", longint'(in_ready), 0);
      check_output("rst_out_valid", longint'(out_valid), 0);
      check_output("rst_dout", longint'(dout), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check_output("post_rst_in_ready", longint'(in_ready), 1);
   endtask

   // mode 0: DC 1024, mode 1: constant -1, otherwise random data and handshakes.
   task automatic apply_stimulus(input int mode, input int n_out, input int bound);
      int target;
      int cycles;
      target = out_count + n_out;
      cycles = 0;
      while (cycles < bound) begin
         @(posedge clock); #1;
         if (out_count >= target) break;
         case (mode)
            0: begin in_valid = 1'b1; din = 1024; out_ready = 1'b1; end
            1: begin in_valid = 1'b1; din = -1;   out_ready = 1'b1; end
            default: begin
               in_valid  = 1'($urandom_range(0, 1));
               din       = $urandom;
               out_ready = 1'($urandom_range(0, 1));
            end
         endcase
         cycles++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check_output("stream_reached_target", longint'(out_count >= target), 1);
   endtask

   // Presents DECIM back-to-back samples starting at posedge+1.
   task automatic feed_block();
      in_valid = 1'b1;
      for (int i = 0; i < DECIM; i++) begin
         din = $urandom;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      longint coeff_sum;
      int     seen;
      int     bad;
      int     snap;
      int     cyc;
      int     first_high;
      longint held;

      coeff_sum = 0;
      foreach (AUDIO_LPR_COEFFS[i]) coeff_sum += longint'(AUDIO_LPR_COEFFS[i]);

      // Reset then idle: nothing may come out without input.
      apply_reset();
      seen = 0;
      repeat (100) begin
         @(negedge clock);
         if (out_valid) seen++;
      end
      check_output("idle_no_output", seen, 0);
      check_output("idle_in_ready", longint'(in_ready), 1);
      check_output("idle_dout", longint'(dout), 0);

      // DC input: early outputs are partial sums, steady state is the coefficient sum.
      apply_reset();
      apply_stimulus(0, 6, 600);
      check_output("dc_steady", last_out, coeff_sum);

      // Truncation toward zero: -1 times small positive coefficients gives 0 per tap.
      apply_reset();
      apply_stimulus(1, 4, 400);
      check_output("trunc_zero", last_out, 0);

      // Random data with random handshakes on both sides.
      apply_reset();
      apply_stimulus(2, 20, 5000);

      // Backpressure: result held stable, no input accepted, then a single handshake.
      apply_reset();
      @(posedge clock); #1;
      in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock); #1;
         if (out_valid) break;
         din = $urandom;
      end
      check_output("bp_out_valid_rise", longint'(out_valid), 1);
      held = longint'(dout);
      snap = accept_count;
      bad  = 0;
      repeat (50) begin
         @(negedge clock);
         if (!out_valid || longint'(dout) != held || in_ready) bad++;
      end
      check_output("bp_hold_violations", bad, 0);
      @(posedge clock); #1;
      check_output("bp_no_accepts", accept_count, snap);
      snap = out_count;
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clock); #1;
      out_ready = 1'b0;
      @(negedge clock);
      check_output("bp_in_ready_after", longint'(in_ready), 1);
      check_output("bp_out_valid_after", longint'(out_valid), 0);
      repeat (5) @(posedge clock);
      #1;
      check_output("bp_one_handshake", out_count, snap + 1);

      // Latency: DECIM back-to-back accepts from cycle 0, out_valid first seen at cycle 40.
      apply_reset();
      @(posedge clock); #1;
      out_ready = 1'b1;
      snap = accept_count;
      feed_block();
      cyc = DECIM - 1;
      first_high = -1;
      while (cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (out_valid) begin
            first_high = cyc;
            break;
         end
      end
      check_output("latency_first_valid", first_high, DECIM + NUM_TAPS);
      check_output("latency_accepts", accept_count - snap, DECIM);
      check_output("latency_in_ready_low", longint'(in_ready), 0);
      @(negedge clock);
      check_output("latency_in_ready_after", longint'(in_ready), 1);

      // Reset at tap 15 of a computation: outputs clear at once, result discarded.
      @(posedge clock); #1;
      feed_block();
      repeat (15) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check_output("midrst_out_valid", longint'(out_valid), 0);
      check_output("midrst_dout", longint'(dout), 0);
      check_output("midrst_in_ready", longint'(in_ready), 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock); #1;
      snap = out_count;
      feed_block();
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         if (out_count > snap) break;
      end
      check_output("midrst_next_output", out_count - snap, 1);
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
